// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and datapath width.
// Used by mem_stage and mem_lane_align (sub-word support selected by MEM_SUBWORD_EN).
package mips_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: store replication and byte enables, load extract/extend,
// misalign detection. Sub-word support only when MEM_SUBWORD_EN is defined.
module mem_lane_align
   import mips_pkg::*;
(
   input  logic [1:0]        addr_lo_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        be_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misalign_o
);

`ifdef MEM_SUBWORD_EN
   logic [DATA_W-1:0] shifted;

   // Move the addressed lane down to bit 0 before extension.
   assign shifted = rdata_i >> {addr_lo_i, 3'b000};

   always_comb begin
      wdata_o    = store_data_i;
      be_o       = 4'hF;
      rdata_o    = rdata_i;
      misalign_o = 1'b0;
      unique case (size_i)
         MEM_SIZE_B: begin
            wdata_o = {4{store_data_i[7:0]}};
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = signed_i ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
         end
         MEM_SIZE_H: begin
            wdata_o    = {2{store_data_i[15:0]}};
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            rdata_o    = signed_i ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'b0, shifted[15:0]};
            misalign_o = addr_lo_i[0];
         end
         default: begin
            misalign_o = (addr_lo_i != 2'b00);
         end
      endcase
   end
`else
   logic unused_sub;

   assign unused_sub = ^{addr_lo_i, size_i, signed_i};
   assign wdata_o    = store_data_i;
   assign be_o       = 4'hF;
   assign rdata_o    = rdata_i;
   assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX result register plus req/gnt/rvalid data-memory FSM.
// Define MEM_SUBWORD_EN for byte/half accesses and misalign dropping.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_i,
   input  logic [31:0]       aluResult_i,
   input  logic [31:0]       storeData_i,
   input  logic [4:0]        wb_addr_i,
   input  logic              c_MemRead_i,
   input  logic              c_MemWrite_i,
   input  logic [1:0]        c_MemSize_i,
   input  logic              c_MemSigned_i,
   input  logic              c_WBSrc2_i,
   input  logic              c_RegWrite_i,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       wbData_temp_o,
   output logic [31:0]       memData_o,
   output logic [4:0]        wb_addr_o,
   output logic              c_WBSrc2_o,
   output logic              c_RegWrite_o,
   output logic              mem_misalign_o
);

   logic        valid_q, rd_q, wr_q, signed_q, wbsrc2_q, regwrite_q;
   logic [31:0] alu_q, store_q;
   logic [4:0]  wb_addr_q;
   logic [1:0]  size_q;

   mem_state_e  state_q, state_d;
   logic        mem_op, misalign_raw, misalign, pending, load_done;
   logic [31:0] wdata_fmt, rdata_fmt;
   logic [3:0]  be_fmt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         alu_q      <= '0;
         store_q    <= '0;
         wb_addr_q  <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         size_q     <= MEM_SIZE_B;
         signed_q   <= 1'b0;
         wbsrc2_q   <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (!mem_stall) begin
         valid_q    <= valid_i;
         alu_q      <= aluResult_i;
         store_q    <= storeData_i;
         wb_addr_q  <= wb_addr_i;
         rd_q       <= c_MemRead_i;
         wr_q       <= c_MemWrite_i;
         size_q     <= c_MemSize_i;
         signed_q   <= c_MemSigned_i;
         wbsrc2_q   <= c_WBSrc2_i;
         regwrite_q <= c_RegWrite_i;
      end
   end

   mem_lane_align u_align (
      .addr_lo_i    (alu_q[1:0]),
      .size_i       (size_q),
      .signed_i     (signed_q),
      .store_data_i (store_q),
      .rdata_i      (dmem_rdata),
      .wdata_o      (wdata_fmt),
      .be_o         (be_fmt),
      .rdata_o      (rdata_fmt),
      .misalign_o   (misalign_raw)
   );

   assign mem_op   = valid_q & (rd_q | wr_q);
   assign misalign = mem_op & misalign_raw;
   assign pending  = mem_op & ~misalign_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      load_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pending) begin
               dmem_req = 1'b1;
               if (!dmem_gnt) begin
                  mem_stall = 1'b1;
               end else if (rd_q) begin
                  mem_stall = 1'b1;
                  state_d   = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (dmem_rvalid) begin
               load_done = 1'b1;
               state_d   = S_IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Port data is gated by req so the bus reads all-zero when idle.
   assign dmem_we        = dmem_req & wr_q;
   assign dmem_addr      = {alu_q[ADDR_W-1:2], 2'b00};
   assign dmem_wdata     = dmem_req ? wdata_fmt : '0;
   assign dmem_be        = dmem_req ? be_fmt : 4'h0;
   assign wbData_temp_o  = alu_q;
   assign memData_o      = load_done ? rdata_fmt : '0;
   assign wb_addr_o      = wb_addr_q;
   assign c_WBSrc2_o     = wbsrc2_q;
   assign c_RegWrite_o   = valid_q & regwrite_q & ~mem_stall & ~misalign;
   assign mem_misalign_o = misalign;

endmodule
